// File: rtl/queue_master_pkg.sv
// Shared types and constants for the queue master.
package queue_master_pkg;

    localparam int QM_N_DEFAULT = 8;
    localparam int QM_DEPTH     = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_TURN  = 2'd2,
        ST_READ  = 2'd3
    } qm_state_e;

endpackage

// File: rtl/io_tristate.sv
// Tri-state pad wrapper: the only driver of the shared queue bus.
module io_tristate #(
    parameter int W = 8
) (
    input  logic [W-1:0] dout_i,
    input  logic         oe_i,
    inout  wire  [W-1:0] pad_io,
    output logic [W-1:0] din_o
);

    assign pad_io = oe_i ? dout_i : {W{1'bz}};
    assign din_o  = pad_io;

endmodule

// File: rtl/queue_master.sv
// Queue master: arbitrates a push stream and a pop stream onto a shared bidirectional
// queue bus. Optional flush input is enabled by defining QUEUE_MASTER_FLUSH_EN.
module queue_master
    import queue_master_pkg::*;
#(
    parameter int   N        = QM_N_DEFAULT,
    parameter logic RR_START = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
`ifdef QUEUE_MASTER_FLUSH_EN
    input  logic         flush,
`endif
    input  logic         wr_valid,
    input  logic [N-1:0] wr_data,
    output logic         wr_ready,
    input  logic         rd_req,
    output logic         rd_ready,
    output logic [N-1:0] rd_data,
    output logic         rd_valid,
    inout  wire  [N-1:0] q_io,
    output logic         q_en,
    output logic         q_rw,
    output logic         q_reset,
    input  logic         q_empty,
    input  logic         q_full
);

    qm_state_e    state_q, state_d;
    logic         grant_rd_q, grant_rd_d;   // 1: read side holds the grant
    logic         last_wr_q, last_wr_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] rd_data_q, rd_data_d;
    logic         rd_valid_q, rd_valid_d;
    logic         q_reset_q;
    logic         flush_now_s;
    logic         in_idle_s, wr_elig_s, rd_elig_s;
    logic         wr_ready_s, rd_ready_s, wr_acc_s, rd_acc_s;
    logic         q_en_s, q_rw_s, q_oe_s;
    logic [N-1:0] q_din_s;

`ifdef QUEUE_MASTER_FLUSH_EN
    logic flush_pend_q, flush_pend_d;

    // Flush request: serviced in IDLE, otherwise parked until IDLE is reached.
    always_comb begin
        flush_now_s  = (state_q == ST_IDLE) && (flush || flush_pend_q);
        flush_pend_d = (state_q != ST_IDLE) && (flush || flush_pend_q);
    end

    // Pending-flush register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= flush_pend_d;
        end
    end
`else
    assign flush_now_s = 1'b0;
`endif

    // Handshake and arbitration; flags only matter while IDLE.
    always_comb begin
        in_idle_s  = (state_q == ST_IDLE) && reset_n && !flush_now_s;
        wr_elig_s  = wr_valid && !q_full;
        rd_elig_s  = rd_req && !q_empty;
        wr_ready_s = in_idle_s && !q_full && (!grant_rd_q || !rd_elig_s);
        rd_ready_s = in_idle_s && !q_empty && (grant_rd_q || !wr_elig_s);
        wr_acc_s   = wr_valid && wr_ready_s;
        rd_acc_s   = rd_req && rd_ready_s;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            grant_rd_q <= RR_START;
            last_wr_q  <= 1'b0;
            wdata_q    <= {N{1'b0}};
            rd_data_q  <= {N{1'b0}};
            rd_valid_q <= 1'b0;
            q_reset_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            grant_rd_q <= grant_rd_d;
            last_wr_q  <= last_wr_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            q_reset_q  <= 1'b0;
        end
    end

    // Next-state logic; a read right after a write inserts a bus turnaround.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_acc_s) begin
                    state_d = ST_WRITE;
                end else if (rd_acc_s) begin
                    state_d = last_wr_q ? ST_TURN : ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_TURN:  state_d = ST_READ;
            ST_READ:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: grant flips to the other side after every accept.
    always_comb begin
        wdata_d    = wr_acc_s ? wr_data : wdata_q;
        rd_data_d  = (state_q == ST_READ) ? q_din_s : rd_data_q;
        rd_valid_d = (state_q == ST_READ);
        if (wr_acc_s) begin
            grant_rd_d = 1'b1;
            last_wr_d  = 1'b1;
        end else if (rd_acc_s) begin
            grant_rd_d = 1'b0;
            last_wr_d  = 1'b0;
        end else begin
            grant_rd_d = grant_rd_q;
            last_wr_d  = last_wr_q;
        end
    end

    // Queue-side outputs decoded from the current state.
    always_comb begin
        q_en_s = 1'b0;
        q_rw_s = 1'b0;
        q_oe_s = 1'b0;
        case (state_q)
            ST_WRITE: begin
                q_en_s = 1'b1;
                q_rw_s = 1'b1;
                q_oe_s = 1'b1;
            end
            ST_READ: begin
                q_en_s = 1'b1;
                q_rw_s = 1'b0;
                q_oe_s = 1'b0;
            end
            default: begin
                q_en_s = 1'b0;
                q_rw_s = 1'b0;
                q_oe_s = 1'b0;
            end
        endcase
    end

    io_tristate #(.W(N)) u_io (
        .dout_i (wdata_q),
        .oe_i   (q_oe_s),
        .pad_io (q_io),
        .din_o  (q_din_s)
    );

    assign wr_ready = wr_ready_s;
    assign rd_ready = rd_ready_s;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign q_en     = q_en_s;
    assign q_rw     = q_rw_s;
    assign q_reset  = q_reset_q || flush_now_s;

endmodule
